imem_fetch_unit: RTL

Parametrised, word-organised instruction memory with a pipelined fetch port and a program-load port, for the single-cycle and upcoming pipelined RISC-V cores. It replaces hard-coded instruction tables and asynchronous reads. Instructions are loaded through a write port. Fetches take byte addresses and return instructions after a fixed, configurable latency, with alignment and range faults. On reset, a clear sweep fills every word with a NOP before fetches are accepted.

---
 rtl/imem_fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_fetch_unit.sv
// Word-organised instruction memory: a reset-time clear sweep, a pipelined
// fetch port with alignment/range faults, and a program-load write port.
module imem_fetch_unit #(
    parameter int          DEPTH        = 128,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] CLEAR_WORD   = 32'h00000013,
    parameter logic [31:0] FAULT_WORD   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [1:0]  fetch_fault,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_wdata,
    output logic        prog_err,
    output logic        init_done,
    output logic [0:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [1:0] FLT_OK  = 2'b00;
    localparam logic [1:0] FLT_MIS = 2'b01;
    localparam logic [1:0] FLT_OOR = 2'b10;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   mem_q [DEPTH];

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic          vld_q   [READ_LATENCY];
    logic          vld_d   [READ_LATENCY];
    logic [31:0]   instr_q [READ_LATENCY];
    logic [31:0]   instr_d [READ_LATENCY];
    logic [1:0]    fault_q [READ_LATENCY];
    logic [1:0]    fault_d [READ_LATENCY];

    logic          prog_err_q, prog_err_d;

    logic          f_mis, f_oor, p_mis, p_oor;
    logic          accept, prog_ok;

    // Handshake: a fetch is taken on any edge where fetch_req && fetch_ready;
    // the result appears as a single fetch_valid pulse READ_LATENCY cycles on,
    // with no output backpressure.
    always_comb begin
        f_mis  = |fetch_addr[1:0];
        f_oor  = |fetch_addr[31:AW+2];
        p_mis  = |prog_addr[1:0];
        p_oor  = |prog_addr[31:AW+2];
        accept = fetch_req && (state_q == ST_READY);
        prog_ok = prog_we && (state_q == ST_READY) && !p_mis && !p_oor;
        prog_err_d = prog_we && !prog_ok;

        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = CLEAR_WORD;

        if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + AW'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end else if (prog_ok) begin
            mem_we    = 1'b1;
            mem_waddr = prog_addr[AW+1:2];
            mem_wdata = prog_wdata;
        end

        // Stage 0 reads the array before this edge's write lands: read-before-write.
        vld_d[0] = accept;
        if (f_mis) begin
            fault_d[0] = FLT_MIS;
            instr_d[0] = FAULT_WORD;
        end else if (f_oor) begin
            fault_d[0] = FLT_OOR;
            instr_d[0] = FAULT_WORD;
        end else begin
            fault_d[0] = FLT_OK;
            instr_d[0] = mem_q[fetch_addr[AW+1:2]];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            instr_d[i] = instr_q[i-1];
            fault_d[i] = fault_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            prog_err_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i]   <= 1'b0;
                instr_q[i] <= '0;
                fault_q[i] <= FLT_OK;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prog_err_q <= prog_err_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                vld_q[i]   <= vld_d[i];
                instr_q[i] <= instr_d[i];
                fault_q[i] <= fault_d[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign fetch_ready = (state_q == ST_READY);
    assign init_done   = (state_q == ST_READY);
    assign fetch_valid = vld_q[READ_LATENCY-1];
    assign fetch_instr = instr_q[READ_LATENCY-1];
    assign fetch_fault = fault_q[READ_LATENCY-1];
    assign prog_err    = prog_err_q;
    assign dbg_state   = state_q;

endmodule
